mc_control_unit: RTL

MC_CONTROL_UNIT -- requirements
Module: mc_control_unit

---
 rtl/mc_cu_pkg.sv | 87 ++++++++
 rtl/mc_cond_check.sv | 61 ++++++
 rtl/mc_control_unit.sv | 221 ++++++++++++++++++++++
 3 files changed

// File: rtl/mc_cu_pkg.sv
// Shared definitions for the multi-cycle control unit: FSM state encoding,
// instruction field encodings, datapath mux selects and the ALU-control decode.
package mc_cu_pkg;

   typedef enum logic [3:0] {
      FETCH  = 4'd0,
      DECODE = 4'd1,
      MEMADR = 4'd2,
      MEMRD  = 4'd3,
      MEMWB  = 4'd4,
      MEMWR  = 4'd5,
      EXECR  = 4'd6,
      EXECI  = 4'd7,
      ALUWB  = 4'd8,
      BRANCH = 4'd9
   } state_t;

   // Instruction class (op field)
   localparam logic [1:0] OP_DP  = 2'b00;
   localparam logic [1:0] OP_MEM = 2'b01;
   localparam logic [1:0] OP_BR  = 2'b10;
   localparam logic [1:0] OP_ILL = 2'b11;

   // Data-processing commands (funct[4:1])
   localparam logic [3:0] CMD_AND = 4'b0000;
   localparam logic [3:0] CMD_SUB = 4'b0010;
   localparam logic [3:0] CMD_ADD = 4'b0100;
   localparam logic [3:0] CMD_CMP = 4'b1010;
   localparam logic [3:0] CMD_ORR = 4'b1100;

   // Condition field encodings
   localparam logic [3:0] COND_EQ = 4'b0000;
   localparam logic [3:0] COND_NE = 4'b0001;
   localparam logic [3:0] COND_CS = 4'b0010;
   localparam logic [3:0] COND_CC = 4'b0011;
   localparam logic [3:0] COND_MI = 4'b0100;
   localparam logic [3:0] COND_PL = 4'b0101;
   localparam logic [3:0] COND_VS = 4'b0110;
   localparam logic [3:0] COND_VC = 4'b0111;
   localparam logic [3:0] COND_HI = 4'b1000;
   localparam logic [3:0] COND_LS = 4'b1001;
   localparam logic [3:0] COND_GE = 4'b1010;
   localparam logic [3:0] COND_LT = 4'b1011;
   localparam logic [3:0] COND_GT = 4'b1100;
   localparam logic [3:0] COND_LE = 4'b1101;
   localparam logic [3:0] COND_AL = 4'b1110;
   localparam logic [3:0] COND_NV = 4'b1111;

   // ALU operand A select
   localparam logic [1:0] SRC_A_REG  = 2'b00;
   localparam logic [1:0] SRC_A_PC   = 2'b10;
   // ALU operand B select
   localparam logic [1:0] SRC_B_REG  = 2'b00;
   localparam logic [1:0] SRC_B_IMM  = 2'b01;
   localparam logic [1:0] SRC_B_FOUR = 2'b10;
   // Result bus select
   localparam logic [1:0] RES_ALU_OUT = 2'b00;
   localparam logic [1:0] RES_MEM     = 2'b01;
   localparam logic [1:0] RES_ALU     = 2'b10;
   // ALU operation
   localparam logic [1:0] ALU_ADD = 2'b00;
   localparam logic [1:0] ALU_SUB = 2'b01;
   localparam logic [1:0] ALU_AND = 2'b10;
   localparam logic [1:0] ALU_ORR = 2'b11;
   // Register-file write source for branch-with-link
   localparam logic [1:0] REG_SRC_LINK = 2'b11;

   // Map a data-processing command onto the ALU operation; unknown commands add.
   function automatic logic [1:0] alu_ctrl_of(input logic [3:0] cmd);
      logic [1:0] ctrl;
      case (cmd)
         CMD_ADD: ctrl = ALU_ADD;
         CMD_SUB: ctrl = ALU_SUB;
         CMD_CMP: ctrl = ALU_SUB;
         CMD_AND: ctrl = ALU_AND;
         CMD_ORR: ctrl = ALU_ORR;
         default: ctrl = ALU_ADD;
      endcase
      return ctrl;
   endfunction

   // Commands whose carry/overflow outputs are meaningful.
   function automatic logic is_arith(input logic [3:0] cmd);
      return (cmd == CMD_ADD) || (cmd == CMD_SUB) || (cmd == CMD_CMP);
   endfunction

endpackage

// File: rtl/mc_cond_check.sv
// NZCV flags register plus evaluation of the instruction condition field
// against the stored flags. Condition 1111 is never satisfied.
module mc_cond_check
   import mc_cu_pkg::*;
(
   input  logic       clk,
   input  logic       reset,
   input  logic       nz_we,
   input  logic       cv_we,
   input  logic [3:0] alu_flags,
   input  logic [3:0] cond,
   output logic       cond_ok
);

   logic [3:0] flags_r;
   logic       n_s, z_s, c_s, v_s;

   // Flags register: NZ and CV halves load independently.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         flags_r <= 4'b0000;
      end else begin
         if (nz_we) begin
            flags_r[3:2] <= alu_flags[3:2];
         end
         if (cv_we) begin
            flags_r[1:0] <= alu_flags[1:0];
         end
      end
   end

   assign n_s = flags_r[3];
   assign z_s = flags_r[2];
   assign c_s = flags_r[1];
   assign v_s = flags_r[0];

   // Condition evaluation against the stored flags.
   always_comb begin
      cond_ok = 1'b0;
      case (cond)
         COND_EQ: cond_ok = z_s;
         COND_NE: cond_ok = !z_s;
         COND_CS: cond_ok = c_s;
         COND_CC: cond_ok = !c_s;
         COND_MI: cond_ok = n_s;
         COND_PL: cond_ok = !n_s;
         COND_VS: cond_ok = v_s;
         COND_VC: cond_ok = !v_s;
         COND_HI: cond_ok = c_s && !z_s;
         COND_LS: cond_ok = !c_s || z_s;
         COND_GE: cond_ok = (n_s == v_s);
         COND_LT: cond_ok = (n_s != v_s);
         COND_GT: cond_ok = !z_s && (n_s == v_s);
         COND_LE: cond_ok = z_s || (n_s != v_s);
         COND_AL: cond_ok = 1'b1;
         COND_NV: cond_ok = 1'b0;
         default: cond_ok = 1'b0;
      endcase
   end

endmodule

// File: rtl/mc_control_unit.sv
// Multi-cycle processor control unit: main FSM sequencing fetch, decode,
// memory, data-processing and branch instructions, driving datapath selects
// and write strobes. Write strobes are forced low while reset is held.
// Optional feature: define CU_PERF_CNT_EN to add the retired-instruction
// counter and its instr_count port.
module mc_control_unit
   import mc_cu_pkg::*;
#(
   parameter int REG_ADDR_W = 4,
   parameter int CNT_W      = 32
)(
   input  logic                  clk,
   input  logic                  reset,
   input  logic [1:0]            op,
   input  logic [5:0]            funct,
   input  logic [REG_ADDR_W-1:0] rd,
   input  logic [3:0]            cond,
   input  logic [3:0]            alu_flags,
   input  logic                  mem_ready,
   output logic                  pc_write,
   output logic                  adr_src,
   output logic                  mem_write,
   output logic                  ir_write,
   output logic                  reg_write,
   output logic                  instr_done,
   output logic [1:0]            result_src,
   output logic [1:0]            alu_src_a,
   output logic [1:0]            alu_src_b,
   output logic [1:0]            alu_control,
   output logic [1:0]            imm_src,
   output logic [1:0]            reg_src
`ifdef CU_PERF_CNT_EN
   ,
   output logic [CNT_W-1:0]      instr_count
`endif
);

   state_t     state_r, state_s;
   logic       cond_ok_s;
   logic       nz_we_s, cv_we_s;
   logic       pc_write_s, mem_write_s, ir_write_s, reg_write_s, instr_done_s;
   logic       rd_is_pc_s;
   logic       i_bit_s, s_bit_s;
   logic [3:0] cmd_s;

   assign i_bit_s    = funct[5];
   assign cmd_s      = funct[4:1];
   assign s_bit_s    = funct[0];
   assign rd_is_pc_s = (rd == {REG_ADDR_W{1'b1}});

   mc_cond_check u_cond (
      .clk       (clk),
      .reset     (reset),
      .nz_we     (nz_we_s),
      .cv_we     (cv_we_s),
      .alu_flags (alu_flags),
      .cond      (cond),
      .cond_ok   (cond_ok_s)
   );

   // State register; reset abandons any instruction in flight.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_r <= FETCH;
      end else begin
         state_r <= state_s;
      end
   end

   // Next-state and per-state output decode.
   always_comb begin
      state_s      = state_r;
      pc_write_s   = 1'b0;
      adr_src      = 1'b0;
      mem_write_s  = 1'b0;
      ir_write_s   = 1'b0;
      reg_write_s  = 1'b0;
      instr_done_s = 1'b0;
      result_src   = 2'b00;
      alu_src_a    = 2'b00;
      alu_src_b    = 2'b00;
      alu_control  = 2'b00;
      reg_src      = {(op == OP_MEM), (op == OP_BR)};
      nz_we_s      = 1'b0;
      cv_we_s      = 1'b0;
      case (state_r)
         FETCH: begin
            alu_src_a  = SRC_A_PC;
            alu_src_b  = SRC_B_FOUR;
            result_src = RES_ALU;
            ir_write_s = mem_ready;
            pc_write_s = mem_ready;
            if (mem_ready) begin
               state_s = DECODE;
            end else begin
               state_s = FETCH;
            end
         end
         DECODE: begin
            alu_src_a  = SRC_A_PC;
            alu_src_b  = SRC_B_FOUR;
            result_src = RES_ALU;
            if (!cond_ok_s) begin
               instr_done_s = 1'b1;
               state_s      = FETCH;
            end else begin
               case (op)
                  OP_MEM: state_s = MEMADR;
                  OP_DP: begin
                     if (i_bit_s) begin
                        state_s = EXECI;
                     end else begin
                        state_s = EXECR;
                     end
                  end
                  OP_BR:  state_s = BRANCH;
                  default: begin
                     instr_done_s = 1'b1;
                     state_s      = FETCH;
                  end
               endcase
            end
         end
         MEMADR: begin
            alu_src_b   = SRC_B_IMM;
            alu_control = ALU_ADD;
            if (s_bit_s) begin
               state_s = MEMRD;
            end else begin
               state_s = MEMWR;
            end
         end
         MEMRD: begin
            adr_src = 1'b1;
            if (mem_ready) begin
               state_s = MEMWB;
            end else begin
               state_s = MEMRD;
            end
         end
         MEMWR: begin
            adr_src     = 1'b1;
            mem_write_s = 1'b1;
            if (mem_ready) begin
               instr_done_s = 1'b1;
               state_s      = FETCH;
            end else begin
               state_s = MEMWR;
            end
         end
         MEMWB: begin
            result_src   = RES_MEM;
            reg_write_s  = 1'b1;
            pc_write_s   = rd_is_pc_s;
            instr_done_s = 1'b1;
            state_s      = FETCH;
         end
         EXECR: begin
            alu_src_b   = SRC_B_REG;
            alu_control = alu_ctrl_of(cmd_s);
            state_s     = ALUWB;
         end
         EXECI: begin
            alu_src_b   = SRC_B_IMM;
            alu_control = alu_ctrl_of(cmd_s);
            state_s     = ALUWB;
         end
         ALUWB: begin
            // CMP only sets flags; it never writes a register.
            result_src   = RES_ALU_OUT;
            reg_write_s  = (cmd_s != CMD_CMP);
            pc_write_s   = (cmd_s != CMD_CMP) && rd_is_pc_s;
            instr_done_s = 1'b1;
            nz_we_s      = s_bit_s || (cmd_s == CMD_CMP);
            cv_we_s      = (s_bit_s || (cmd_s == CMD_CMP)) && is_arith(cmd_s);
            state_s      = FETCH;
         end
         BRANCH: begin
            alu_src_b    = SRC_B_IMM;
            result_src   = RES_ALU;
            pc_write_s   = 1'b1;
            instr_done_s = 1'b1;
            if (funct[4]) begin
               reg_write_s = 1'b1;
               reg_src     = REG_SRC_LINK;
            end else begin
               reg_write_s = 1'b0;
            end
            state_s = FETCH;
         end
         default: begin
            state_s = FETCH;
         end
      endcase
   end

   assign imm_src    = op;
   assign pc_write   = pc_write_s   & reset;
   assign mem_write  = mem_write_s  & reset;
   assign ir_write   = ir_write_s   & reset;
   assign reg_write  = reg_write_s  & reset;
   assign instr_done = instr_done_s & reset;

`ifdef CU_PERF_CNT_EN
   logic [CNT_W-1:0] instr_count_r;

   // Retired-instruction counter, wraps naturally at all-ones.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         instr_count_r <= {CNT_W{1'b0}};
      end else if (instr_done) begin
         instr_count_r <= instr_count_r + {{(CNT_W-1){1'b0}}, 1'b1};
      end else begin
         instr_count_r <= instr_count_r;
      end
   end

   assign instr_count = instr_count_r;
`endif

endmodule
